// File: rtl/ula_stack_pkg.sv
// Shared opcode and FSM definitions for the ULA stack engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ula_stack_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_PUSH    = 4'd1,
        OP_POP     = 4'd2,
        OP_DUP     = 4'd3,
        OP_ROT_TWO = 4'd4,
        OP_ADD     = 4'd5,
        OP_SUB     = 4'd6,
        OP_MUL     = 4'd7,
        OP_AND     = 4'd8,
        OP_OR      = 4'd9,
        OP_XOR     = 4'd10,
        OP_CMP_LT  = 4'd11,
        OP_CMP_EQ  = 4'd12
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // Minimum number of stack entries an opcode consumes.
    function automatic logic [1:0] needs_operands(input logic [3:0] op);
        logic [1:0] n;
        case (op)
            OP_POP, OP_DUP:                         n = 2'd1;
            OP_ROT_TWO, OP_ADD, OP_SUB, OP_MUL,
            OP_AND, OP_OR, OP_XOR,
            OP_CMP_LT, OP_CMP_EQ:                   n = 2'd2;
            default:                                n = 2'd0;
        endcase
        return n;
    endfunction

    // Opcodes that grow the stack by one entry.
    function automatic logic pushes(input logic [3:0] op);
        return (op == OP_PUSH) || (op == OP_DUP);
    endfunction

endpackage

// File: rtl/ula_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, product truncated to WIDTH.
// Latency: start at edge E, done asserted during the WIDTH-th cycle after E (product valid with done).
// Backpressure: none; start is only legal while idle, the caller holds off commands until done.
// Ports: start/multiplicand/multiplier load operands; done + product present the final sum combinationally.
module ula_seq_mul #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic             run;
    logic [WIDTH-1:0] partial;

    // product is the accumulator after this cycle's step, so the final
    // step's result can be consumed in the same cycle done is high.
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign done    = run && (cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNTW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_stack_engine.sv
// Operand stack with bytecode ALU (push/pop/dup/rot, arith, logic, compare) behind a valid/ready port.
// Latency: single-cycle ops visible the cycle after acceptance; MUL result ULA_WIDTH+1 cycles after.
// Backpressure: cmd_ready drops for the whole multiply; faulting commands are still accepted.
// Ports: cmd_* command handshake; tos_out/nos_out/stack_count stack view; busy; sticky err_* with err_clear.
module ula_stack_engine
    import ula_stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ULA_WIDTH   = 24,
    parameter int STACK_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [3:0]                       cmd_op,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    output logic [ULA_WIDTH-1:0]             tos_out,
    output logic [ULA_WIDTH-1:0]             nos_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             busy,
    output logic                             err_underflow,
    output logic                             err_overflow,
    output logic                             err_illegal,
    input  logic                             err_clear
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [ULA_WIDTH-1:0] mem [STACK_DEPTH];
    logic [CW-1:0]        ptr;
    logic [CW-1:0]        ptr_nxt;
    state_e               state;

    logic [AW-1:0]        tos_idx, nos_idx, push_idx;
    logic [ULA_WIDTH-1:0] tos_val, nos_val, imm, alu_res;
    logic                 accept, new_under, new_over, new_ill, fault;
    logic                 wr_en, wr2_en, mul_start, mul_done;
    logic [AW-1:0]        wr_idx, wr2_idx;
    logic [ULA_WIDTH-1:0] wr_dat, wr2_dat, mul_product;

    // Index arithmetic may go out of range when ptr is small or full;
    // every use is gated by count or by the fault checks.
    assign tos_idx  = AW'(ptr - CW'(1));
    assign nos_idx  = AW'(ptr - CW'(2));
    assign push_idx = AW'(ptr);

    assign tos_val = (ptr >= CW'(1)) ? mem[tos_idx] : '0;
    assign nos_val = (ptr >= CW'(2)) ? mem[nos_idx] : '0;

    assign tos_out     = tos_val;
    assign nos_out     = nos_val;
    assign stack_count = ptr;

    assign imm = ULA_WIDTH'($signed(cmd_data));

    assign accept    = cmd_valid && cmd_ready;
    assign new_ill   = accept && (cmd_op > OP_CMP_EQ);
    assign new_under = accept && (ptr < CW'(needs_operands(cmd_op)));
    assign new_over  = accept && pushes(cmd_op) && (ptr == CW'(STACK_DEPTH));
    assign fault     = new_ill || new_under || new_over;

    // Operand a = NOS, b = TOS.
    always_comb begin
        alu_res = '0;
        case (cmd_op)
            OP_ADD:    alu_res = nos_val + tos_val;
            OP_SUB:    alu_res = nos_val - tos_val;
            OP_AND:    alu_res = nos_val & tos_val;
            OP_OR:     alu_res = nos_val | tos_val;
            OP_XOR:    alu_res = nos_val ^ tos_val;
            OP_CMP_LT: alu_res = ULA_WIDTH'($signed(nos_val) < $signed(tos_val));
            OP_CMP_EQ: alu_res = ULA_WIDTH'(nos_val == tos_val);
            default:   alu_res = '0;
        endcase
    end

    // Stack update decode; a second write port exists only for ROT_TWO.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = push_idx;
        wr_dat    = alu_res;
        wr2_en    = 1'b0;
        wr2_idx   = nos_idx;
        wr2_dat   = tos_val;
        ptr_nxt   = ptr;
        mul_start = 1'b0;
        if (state == MUL) begin
            if (mul_done) begin
                wr_en   = 1'b1;
                wr_idx  = nos_idx;
                wr_dat  = mul_product;
                ptr_nxt = ptr - CW'(1);
            end
        end else if (accept && !fault) begin
            case (cmd_op)
                OP_PUSH: begin
                    wr_en   = 1'b1;
                    wr_dat  = imm;
                    ptr_nxt = ptr + CW'(1);
                end
                OP_POP: ptr_nxt = ptr - CW'(1);
                OP_DUP: begin
                    wr_en   = 1'b1;
                    wr_dat  = tos_val;
                    ptr_nxt = ptr + CW'(1);
                end
                OP_ROT_TWO: begin
                    wr_en  = 1'b1;
                    wr_idx = tos_idx;
                    wr_dat = nos_val;
                    wr2_en = 1'b1;
                end
                OP_MUL: mul_start = 1'b1;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP_LT, OP_CMP_EQ: begin
                    wr_en   = 1'b1;
                    wr_idx  = nos_idx;
                    ptr_nxt = ptr - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                mem[wr_idx] <= wr_dat;
            end
            if (wr2_en) begin
                mem[wr2_idx] <= wr2_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            state         <= IDLE;
            busy          <= 1'b0;
            cmd_ready     <= 1'b1;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_illegal   <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            // err_clear drops old flags while still latching a same-cycle error.
            err_underflow <= new_under || (err_underflow && !err_clear);
            err_overflow  <= new_over  || (err_overflow  && !err_clear);
            err_illegal   <= new_ill   || (err_illegal   && !err_clear);
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state     <= MUL;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ula_seq_mul #(
        .WIDTH(ULA_WIDTH)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (nos_val),
        .multiplier   (tos_val),
        .done         (mul_done),
        .product      (mul_product)
    );

endmodule

// File: tb/tb_ula_stack_engine.sv
// Randomised + directed bench for ula_stack_engine with a queue-based stack model.
// Latency: expected state checked the cycle after acceptance, or after the busy window for MUL.
// Backpressure: stimulus holds cmd_valid until cmd_ready; monitor tracks busy/ready cycles.
module tb_ula_stack_engine;

    localparam int DW = 8;
    localparam int W  = 24;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    localparam int OP_NOP = 0, OP_PUSH = 1, OP_POP = 2, OP_DUP = 3, OP_ROT = 4;
    localparam int OP_ADD = 5, OP_SUB = 6, OP_MUL = 7, OP_AND = 8, OP_OR = 9;
    localparam int OP_XOR = 10, OP_LT = 11, OP_EQ = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [W-1:0]  tos_out;
    logic [W-1:0]  nos_out;
    logic [CW-1:0] stack_count;
    logic          busy;
    logic          err_underflow;
    logic          err_overflow;
    logic          err_illegal;
    logic          err_clear;

    always #5 clk = ~clk;

    ula_stack_engine #(
        .DATA_WIDTH  (DW),
        .ULA_WIDTH   (W),
        .STACK_DEPTH (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .tos_out       (tos_out),
        .nos_out       (nos_out),
        .stack_count   (stack_count),
        .busy          (busy),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_illegal   (err_illegal),
        .err_clear     (err_clear)
    );

    typedef struct {
        logic [W-1:0] tos;
        logic [W-1:0] nos;
        int           cnt;
        bit           eu;
        bit           eo;
        bit           ei;
        int           busy;
        logic [W-1:0] htos;
        logic [W-1:0] hnos;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    exp_t         q[$];
    logic [W-1:0] ms[$];
    bit           m_eu, m_eo, m_ei;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] peek(input int k);
        if (ms.size() > k) return ms[ms.size() - 1 - k];
        return '0;
    endfunction

    // Reference model: stack as a queue, results from plain arithmetic.
    task automatic model(input int op, input logic [DW-1:0] d, input bit ec);
        exp_t         e;
        logic [W-1:0] a, b, r;
        bit           u, o, il;
        int           n;
        n  = ms.size();
        u  = 0; o = 0; il = 0; r = '0;
        a  = peek(1);
        b  = peek(0);
        e.htos = b;
        e.hnos = a;
        e.busy = 0;
        if (op >= 13)          il = 1;
        else if (op == OP_POP) u = (n < 1);
        else if (op == OP_DUP) begin u = (n < 1); o = (n >= D); end
        else if (op == OP_PUSH) o = (n >= D);
        else if (op >= OP_ROT) u = (n < 2);
        if (!(u || o || il)) begin
            if (op == OP_PUSH)     ms.push_back({{(W-DW){d[DW-1]}}, d});
            else if (op == OP_POP) void'(ms.pop_back());
            else if (op == OP_DUP) ms.push_back(b);
            else if (op == OP_ROT) begin ms[n-1] = a; ms[n-2] = b; end
            else if (op >= OP_ADD) begin
                case (op)
                    OP_ADD: r = a + b;
                    OP_SUB: r = a - b;
                    OP_MUL: begin r = a * b; e.busy = W; end
                    OP_AND: r = a & b;
                    OP_OR:  r = a | b;
                    OP_XOR: r = a ^ b;
                    OP_LT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
                    OP_EQ:  r = (a == b) ? 1 : 0;
                    default: r = '0;
                endcase
                void'(ms.pop_back());
                ms[n-2] = r;
            end
        end
        m_eu = u  || (m_eu && !ec);
        m_eo = o  || (m_eo && !ec);
        m_ei = il || (m_ei && !ec);
        e.tos = peek(0);
        e.nos = peek(1);
        e.cnt = ms.size();
        e.eu  = m_eu;
        e.eo  = m_eo;
        e.ei  = m_ei;
        q.push_back(e);
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic issue(input int op, input logic [DW-1:0] d, input bit ec);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op[3:0];
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            finish_now();
        end
        err_clear = ec;
        model(op, d, ec);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_count"}, 32'(stack_count), 32'd0);
        chk({tag, "_tos"},   32'(tos_out), 32'd0);
        chk({tag, "_nos"},   32'(nos_out), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_eu"},    32'(err_underflow), 32'd0);
        chk({tag, "_eo"},    32'(err_overflow), 32'd0);
        chk({tag, "_ei"},    32'(err_illegal), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ms.delete();
        m_eu = 0; m_eo = 0; m_ei = 0;
        @(negedge clk);
        reset_check(tag);
    endtask

    // Monitor: pops one expectation per accepted command once busy is low.
    bit pending = 0;
    int bcnt = 0;
    int rlow = 0;

    always @(posedge clk) begin
        if (reset) begin
            pending = 0;
            bcnt    = 0;
            rlow    = 0;
            q.delete();
        end else if (cmd_valid && cmd_ready) begin
            pending = 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && pending) begin
            if (q.size() == 0) begin
                chk("queue_underrun", 32'(q.size()), 32'd1);
                pending = 0;
            end else if (busy) begin
                bcnt++;
                if (!cmd_ready) rlow++;
                chk("hold_tos", 32'(tos_out), 32'(q[0].htos));
                chk("hold_nos", 32'(nos_out), 32'(q[0].hnos));
            end else begin
                e = q.pop_front();
                chk("tos",         32'(tos_out), 32'(e.tos));
                chk("nos",         32'(nos_out), 32'(e.nos));
                chk("count",       32'(stack_count), 32'(e.cnt));
                chk("err_under",   32'(err_underflow), 32'(e.eu));
                chk("err_over",    32'(err_overflow), 32'(e.eo));
                chk("err_illegal", 32'(err_illegal), 32'(e.ei));
                chk("busy_cycles", 32'(bcnt), 32'(e.busy));
                chk("ready_low",   32'(rlow), 32'(e.busy));
                chk("ready_after", 32'(cmd_ready), 32'd1);
                pending = 0;
                bcnt    = 0;
                rlow    = 0;
            end
        end
    end

    initial begin
        int op;
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        err_clear = 1'b0;
        m_eu = 0; m_eo = 0; m_ei = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        reset_check("reset");

        // SUB order and signed compare
        issue(OP_PUSH, 8'd5, 0);
        issue(OP_PUSH, 8'd3, 0);
        issue(OP_SUB,  8'd0, 0);
        issue(OP_PUSH, 8'd3, 0);
        issue(OP_LT,   8'd0, 0);
        // underflow with one entry, then clear
        issue(OP_ADD,  8'd0, 0);
        issue(OP_NOP,  8'd0, 1);
        issue(OP_POP,  8'd0, 0);
        // sign extension and truncating add
        issue(OP_PUSH, 8'hFF, 0);
        issue(OP_PUSH, 8'h01, 0);
        issue(OP_ADD,  8'd0, 0);
        issue(OP_POP,  8'd0, 0);
        // multiply; the following NOP is held valid during busy
        issue(OP_PUSH, 8'h12, 0);
        issue(OP_PUSH, 8'h10, 0);
        issue(OP_MUL,  8'd0, 0);
        issue(OP_NOP,  8'd0, 0);
        issue(OP_ROT,  8'd0, 0);
        issue(OP_DUP,  8'd0, 0);
        issue(OP_EQ,   8'd0, 0);
        // fill to depth, overflow, illegal opcode
        while (ms.size() > 0) issue(OP_POP, 8'd0, 0);
        for (int i = 1; i <= D; i++) issue(OP_PUSH, 8'(i), 0);
        issue(OP_PUSH, 8'd17, 0);
        issue(OP_DUP,  8'd0, 0);
        issue(14,      8'd0, 0);
        // reset five cycles into a multiply
        issue(OP_MUL,  8'd0, 0);
        repeat (4) @(negedge clk);
        do_reset("midmul_reset");

        // random phase: push-heavy first half, mixed second half
        for (int i = 0; i < 400; i++) begin
            if (i < 200 && $urandom_range(0, 3) != 0) op = OP_PUSH;
            else op = int'($urandom_range(0, 15));
            issue(op, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
        end

        n = 0;
        while ((q.size() > 0 || pending) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        finish_now();
    end

endmodule

// File: doc/ula_stack_engine.md
Name: ula_stack_engine

Overview:
- Parametrised successor to the current ULA operand block.
- Holds an on-chip operand stack of configurable depth and width, and executes bytecode-style stack operations (push/pop/dup/rot, arithmetic, logic, compare) under a valid/ready command handshake.
- Sits between the bytecode decoder and the memory/register path. TOS and NOS are exposed directly for the jump and argument registers.
- Multiply is iterative; every other operation completes in one cycle.

Parameters:
- DATA_WIDTH, 8: width of the immediate pushed with a command.
- ULA_WIDTH, 24: stack entry and arithmetic width; must be ≥ DATA_WIDTH.
- STACK_DEPTH, 16: number of stack entries; must be ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command this cycle.
- cmd_op  in  4  opcode (encoding below).
- cmd_data  in  DATA_WIDTH  immediate for PUSH; two's complement.
- tos_out  out  ULA_WIDTH  top of stack; 0 when stack is empty.
- nos_out  out  ULA_WIDTH  next on stack; 0 when count < 2.
- stack_count  out  $clog2(STACK_DEPTH+1)  number of valid entries.
- busy  out  1  multiply in progress.
- err_underflow  out  1  sticky: an operation needed more operands than the stack held.
- err_overflow  out  1  sticky: PUSH or DUP attempted on a full stack.
- err_illegal  out  1  sticky: opcode 13–15 received.
- err_clear  in  1  clears all sticky error flags.

Behaviour:
- Opcodes:
  - 0 NOP; 1 PUSH; 2 POP; 3 DUP; 4 ROT_TWO (swap TOS/NOS).
  - 5 ADD; 6 SUB; 7 MUL; 8 AND; 9 OR; 10 XOR.
  - 11 CMP_LT (signed); 12 CMP_EQ.
- Reset: stack_count = 0, tos_out = nos_out = 0, busy = 0, all error flags = 0, cmd_ready = 1, FSM = IDLE. Stack storage contents are don't-care.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready in cycle N.
  - Single-cycle ops update the stack at the end of cycle N; the result is visible on tos_out and stack_count in cycle N+1.
  - cmd_ready is high in IDLE and low in MUL.
- Binary ops (5–12):
  - Operand a = NOS, b = TOS. Result = a op b, i.e. SUB gives NOS − TOS and CMP_LT gives NOS < TOS.
  - Both operands are popped and the result is pushed, so count decreases by 1.
  - Compare results are 1 or 0, zero-extended to ULA_WIDTH.
  - ADD, SUB and MUL results are truncated to ULA_WIDTH, with no carry or overflow flag.
- PUSH: sign-extends cmd_data to ULA_WIDTH.
- DUP: copies TOS.
- POP: discards TOS.
- Operand requirements:
  - Binary ops and ROT_TWO need count ≥ 2.
  - POP and DUP need count ≥ 1.
  - PUSH and DUP need count < STACK_DEPTH.
- Faulting commands: the command is still accepted (handshake completes), the stack is left unchanged, and the corresponding sticky flag is set in cycle N+1.
- Illegal opcodes: accepted; only err_illegal is set.
- FSM:
  - IDLE → MUL on an accepted, non-faulting MUL.
  - MUL runs a shift-add for exactly ULA_WIDTH cycles, one multiplier bit per cycle, with a cycle counter.
  - The product is written over NOS at the end of the last MUL cycle, count decreases by 1, and the FSM returns to IDLE.
  - An MUL accepted in cycle N gives its result in cycle N+ULA_WIDTH+1; busy = 1 in cycles N+1 … N+ULA_WIDTH.
  - tos_out and nos_out keep their pre-MUL values while busy.
- err_clear:
  - Asserted alone, it clears the flags at the next edge.
  - If a new error occurs in the same cycle, the new error's flag is set and all other flags clear.
- Reset mid-MUL: the multiply aborts, the stack empties and FSM = IDLE on the next edge; reset overrides every other input.
- Stack implementation: array indexed by a pointer. tos_out and nos_out are read combinationally from pointer−1 and pointer−2, gated to 0 by count. No wrap-around: the pointer never leaves 0…STACK_DEPTH.

Decomposition:
- Package ula_stack_pkg holds:
  - the opcode enum (4-bit);
  - the FSM state enum {IDLE, MUL};
  - function needs_operands(op) and function pushes(op).
- One sub-module, ula_seq_mul: iterative ULA_WIDTH-cycle shift-add multiplier with start/done.
- The stack array and ALU stay in the top module.

Test Plan:
- PUSH 5, PUSH 3, SUB → tos_out = 2, stack_count = 1; then PUSH 3, CMP_LT → tos_out = 1, the compare being 2 < 3.
- PUSH 0xFF (DATA_WIDTH = 8) → tos_out = 0xFFFFFF; PUSH 0x01, ADD → tos_out = 0x000000, stack_count = 1.
- PUSH 0x12, PUSH 0x10, MUL → cmd_ready low and busy high for exactly 24 cycles, then tos_out = 0x000120, stack_count = 1; a cmd_valid held high during MUL is not accepted.
- count = 1, issue ADD → err_underflow = 1 next cycle, stack_count stays 1, tos_out unchanged; err_clear → flag 0.
- 16 PUSHes of values 1…16 → count 16, tos_out = 16, nos_out = 15; 17th PUSH → err_overflow = 1, count 16; opcode 14 → err_illegal = 1.
- Reset asserted 5 cycles into a MUL → next cycle stack_count = 0, busy = 0, cmd_ready = 1, tos_out = 0, all error flags 0.
